// File: rtl/led_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_disp_pkg
// Brief    : Shared segment codes, run-mode codes and run-control states for
//            the 7-segment countdown scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package led_disp_pkg;

    // Segment patterns, bit order gfedcba, active-low (common-anode digits)
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] MODE_ONESHOT     = 2'b00;
    localparam logic [1:0] MODE_RELOAD      = 2'b01;
    localparam logic [1:0] MODE_RELOAD_ONCE = 2'b10;
    localparam logic [1:0] MODE_FREEZE      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational BCD nibble to active-low 7-segment pattern;
//            non-decimal nibbles produce a blank digit.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import led_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_countdown_scan.sv
`default_nettype none
// ============================================================================
// Module   : led_countdown_scan
// Brief    : Multiplexed common-anode 7-seg driver showing a BCD countdown on
//            the low digits and a fixed BCD ID on the high digits.
// Revision : 1.0 - initial release
// ============================================================================
module led_countdown_scan
    import led_disp_pkg::*;
#(
    parameter int                          N_DIGITS     = 8,
    parameter int                          COUNT_DIGITS = 2,
    parameter int                          SCAN_CYCLES  = 4,
    parameter int                          TICK_CYCLES  = 32,
    parameter logic [4*COUNT_DIGITS-1:0]   START_BCD    = 8'h10,
    parameter logic [31:0]                 ID_BCD       = 32'h0020_1028
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic [1:0]          mode,
    output logic [N_DIGITS-1:0] led_en,
    output logic                led_ca,
    output logic                led_cb,
    output logic                led_cc,
    output logic                led_cd,
    output logic                led_ce,
    output logic                led_cf,
    output logic                led_cg,
    output logic                led_dp,
    output logic                running,
    output logic                done
);

    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam int CNT_W  = 4 * COUNT_DIGITS;

    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_CYCLES - 1);
    localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]  c_idx_top   = IDX_W'(N_DIGITS - 1);

    run_state_t          r_state;
    run_state_t          w_state_nxt;
    logic                r_start_q;
    logic                r_pause_q;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [CNT_W-1:0]    r_count;
    logic                r_reload_once;
    logic                r_done;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [N_DIGITS-1:0] r_led_en;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic                w_start_p;
    logic                w_pause_p;
    logic                w_launch;
    logic                w_run_adv;
    logic                w_tick;
    logic                w_count_zero;
    logic [CNT_W-1:0]    w_count_dec;
    logic                w_borrow;
    logic [3:0]          w_digit [N_DIGITS];
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg;

    assign w_start_p    = start & ~r_start_q;
    assign w_pause_p    = pause & ~r_pause_q;
    assign w_launch     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_start_p;
    // A pause press wins over a same-cycle tick, so the pausing cycle does not count.
    assign w_run_adv    = (r_state == ST_RUN) && !w_pause_p;
    assign w_tick       = w_run_adv && (r_tick_cnt == c_tick_last);
    assign w_count_zero = (r_count == '0);

    always_comb begin
        w_count_dec = r_count;
        w_borrow    = 1'b1;
        for (int i = 0; i < COUNT_DIGITS; i++) begin
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_p) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_pause_p) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_tick && w_count_zero) begin
                    if ((mode == MODE_ONESHOT) ||
                        ((mode == MODE_RELOAD_ONCE) && r_reload_once))
                        w_state_nxt = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (w_pause_p) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q     <= 1'b0;
            r_pause_q     <= 1'b0;
            r_tick_cnt    <= '0;
            r_count       <= START_BCD;
            r_reload_once <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_start_q <= start;
            r_pause_q <= pause;
            r_done    <= 1'b0;
            if (w_launch) begin
                r_tick_cnt    <= '0;
                r_count       <= START_BCD;
                r_reload_once <= 1'b0;
            end else if (w_run_adv) begin
                if (w_tick) begin
                    r_tick_cnt <= '0;
                    if (mode != MODE_FREEZE) begin
                        if (!w_count_zero) begin
                            r_count <= w_count_dec;
                            r_done  <= (w_count_dec == '0);
                        end else if (mode == MODE_RELOAD) begin
                            r_count <= START_BCD;
                        end else if ((mode == MODE_RELOAD_ONCE) && !r_reload_once) begin
                            r_count       <= START_BCD;
                            r_reload_once <= 1'b1;
                        end
                    end
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        if (gi < COUNT_DIGITS) begin : g_count
            assign w_digit[gi] = r_count[4*gi +: 4];
        end else begin : g_id
            assign w_digit[gi] = ID_BCD[4*(gi-COUNT_DIGITS) +: 4];
        end
    end

    assign w_nibble = w_digit[r_scan_idx];

    seg7_decode u_seg7_decode (
        .i_bcd (w_nibble),
        .o_seg (w_seg)
    );

    // Enables and segment data latch on the same edge so a digit never shows its neighbour's data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_scan_idx <= c_idx_top;
            r_led_en   <= '1;
            r_seg      <= SEG_BLANK;
            r_dp       <= 1'b1;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == '0) ? c_idx_top : r_scan_idx - 1'b1;
            r_led_en   <= ~(N_DIGITS'(1) << r_scan_idx);
            r_seg      <= w_seg;
            r_dp       <= !((int'(r_scan_idx) == COUNT_DIGITS) && (r_state == ST_PAUSE));
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign led_en  = r_led_en;
    assign led_ca  = r_seg[0];
    assign led_cb  = r_seg[1];
    assign led_cc  = r_seg[2];
    assign led_cd  = r_seg[3];
    assign led_ce  = r_seg[4];
    assign led_cf  = r_seg[5];
    assign led_cg  = r_seg[6];
    assign led_dp  = r_dp;
    assign running = (r_state == ST_RUN);
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_countdown_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_countdown_scan
// Brief    : Directed self-checking bench for the countdown scan driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_countdown_scan;
    import led_disp_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic [1:0] mode;
    logic [3:0] led_en;
    logic       led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg;
    logic       led_dp;
    logic       running;
    logic       done;
    logic [6:0] seg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    assign seg = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

    led_countdown_scan #(
        .N_DIGITS     (4),
        .COUNT_DIGITS (2),
        .SCAN_CYCLES  (2),
        .TICK_CYCLES  (8),
        .START_BCD    (8'h10),
        .ID_BCD       (32'h0000_0028)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .mode    (mode),
        .led_en  (led_en),
        .led_ca  (led_ca),
        .led_cb  (led_cb),
        .led_cc  (led_cc),
        .led_cd  (led_cd),
        .led_ce  (led_ce),
        .led_cf  (led_cf),
        .led_cg  (led_cg),
        .led_dp  (led_dp),
        .running (running),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since last reset release; drives the bench's own scan-position model.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_digit(input int c);
        int w;
        w = c / 2;
        if (w == 0) return -1;
        return 3 - ((w - 1) % 4);
    endfunction

    function automatic logic [3:0] exp_en(input int d);
        logic [3:0] one;
        one = 4'b0001;
        if (d < 0) return 4'hF;
        return ~(one << d);
    endfunction

    logic [3:0] walk_en  [4];
    logic [6:0] walk_seg [4];
    logic [7:0] dec_seq  [10];
    int         d;

    initial begin
        walk_en  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        walk_seg = '{7'h24, 7'h00, 7'h79, 7'h40};
        dec_seq  = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

        rst = 1'b1; start = 1'b0; pause = 1'b0; mode = 2'b00;
        step(3);
        chk("rst_en",      32'(led_en),      32'hF);
        chk("rst_seg",     32'(seg),         32'h7F);
        chk("rst_dp",      32'(led_dp),      32'h1);
        chk("rst_running", 32'(running),     32'h0);
        chk("rst_done",    32'(done),        32'h0);
        chk("rst_count",   32'(dut.r_count), 32'h10);
        chk("rst_state",   32'(dut.r_state), 32'(ST_IDLE));

        // Idle scan walk: 20 digit slots of 2 cycles each
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(2);
            chk("walk_en",    32'(led_en),      32'(walk_en[k % 4]));
            chk("walk_seg",   32'(seg),         32'(walk_seg[k % 4]));
            chk("walk_done",  32'(done),        32'h0);
            chk("walk_count", 32'(dut.r_count), 32'h10);
        end

        // One-shot countdown
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("os_running0", 32'(running),     32'h1);
        chk("os_count0",   32'(dut.r_count), 32'h10);
        for (int i = 0; i < 10; i++) begin
            step(8);
            chk("os_count", 32'(dut.r_count), 32'(dec_seq[i]));
            chk("os_done",  32'(done),        (i == 9) ? 32'h1 : 32'h0);
        end
        step(1);
        chk("os_done_pulse", 32'(done),    32'h0);
        chk("os_still_run",  32'(running), 32'h1);
        step(7);
        chk("os_running_end", 32'(running),     32'h0);
        chk("os_state_end",   32'(dut.r_state), 32'(ST_DONE));
        chk("os_count_end",   32'(dut.r_count), 32'h00);

        // Auto-reload
        mode  = 2'b01;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("ar_count0", 32'(dut.r_count), 32'h10);
        step(80);
        chk("ar_count00", 32'(dut.r_count), 32'h00);
        chk("ar_done",    32'(done),        32'h1);
        step(8);
        chk("ar_reload",  32'(dut.r_count), 32'h10);
        chk("ar_running", 32'(running),     32'h1);
        chk("ar_done0",   32'(done),        32'h0);

        // Reload-once, switched mid-run
        mode = 2'b10;
        step(80);
        chk("ro_count00a", 32'(dut.r_count), 32'h00);
        chk("ro_done_a",   32'(done),        32'h1);
        step(8);
        chk("ro_reload",   32'(dut.r_count), 32'h10);
        chk("ro_running",  32'(running),     32'h1);
        step(80);
        chk("ro_count00b", 32'(dut.r_count), 32'h00);
        chk("ro_done_b",   32'(done),        32'h1);
        step(8);
        chk("ro_running_end", 32'(running),     32'h0);
        chk("ro_state_end",   32'(dut.r_state), 32'(ST_DONE));

        // Pause mid-tick at 07
        mode  = 2'b00;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(24);
        chk("ps_count07", 32'(dut.r_count), 32'h07);
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("ps_state",   32'(dut.r_state), 32'(ST_PAUSE));
        chk("ps_running", 32'(running),     32'h0);
        step(50);
        chk("ps_hold",    32'(dut.r_count), 32'h07);
        for (int j = 0; j < 8; j++) begin
            step(1);
            d = exp_digit(cyc);
            chk("ps_scan_en", 32'(led_en), 32'(exp_en(d)));
            chk("ps_dp",      32'(led_dp), (d == 2) ? 32'h0 : 32'h1);
        end
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("ps_resume", 32'(running), 32'h1);
        step(4);
        chk("ps_remain_hold", 32'(dut.r_count), 32'h07);
        step(1);
        chk("ps_remain_dec",  32'(dut.r_count), 32'h06);
        step(2);
        d = exp_digit(cyc);
        chk("ps_dp_run", 32'(led_dp), 32'h1);

        // Freeze mode holds the count
        mode = 2'b11;
        step(14);
        chk("fz_hold",    32'(dut.r_count), 32'h06);
        chk("fz_running", 32'(running),     32'h1);
        mode = 2'b00;
        step(8);
        chk("fz_resume_dec", 32'(dut.r_count), 32'h05);

        // Reset in RUN
        rst = 1'b1;
        step(1);
        chk("mr_count",   32'(dut.r_count), 32'h10);
        chk("mr_state",   32'(dut.r_state), 32'(ST_IDLE));
        chk("mr_en",      32'(led_en),      32'hF);
        chk("mr_seg",     32'(seg),         32'h7F);
        chk("mr_running", 32'(running),     32'h0);
        rst = 1'b0;
        step(2);
        chk("mr_scan_en",  32'(led_en), 32'b0111);
        chk("mr_scan_seg", 32'(seg),    32'h24);

        // Simultaneous start+pause: start wins in IDLE, pause wins in RUN
        start = 1'b1; pause = 1'b1;
        step(1);
        chk("sim_idle_run", 32'(dut.r_state), 32'(ST_RUN));
        start = 1'b0; pause = 1'b0;
        step(1);
        start = 1'b1; pause = 1'b1;
        step(1);
        chk("sim_run_pause", 32'(dut.r_state), 32'(ST_PAUSE));
        pause = 1'b0;
        step(1);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("held_resume", 32'(dut.r_state), 32'(ST_RUN));
        step(7);
        chk("held_count09", 32'(dut.r_count), 32'h09);
        step(72);
        chk("held_count00", 32'(dut.r_count), 32'h00);
        step(8);
        chk("held_done_state", 32'(dut.r_state), 32'(ST_DONE));
        step(10);
        chk("held_no_retrig", 32'(dut.r_state), 32'(ST_DONE));
        chk("held_running",   32'(running),     32'h0);

        // Held start across reset counts as a fresh press
        rst = 1'b1;
        step(1);
        chk("hr_idle", 32'(dut.r_state), 32'(ST_IDLE));
        rst = 1'b0;
        step(1);
        chk("hr_run", 32'(dut.r_state), 32'(ST_RUN));
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
